sm_add_arbiter: RTL and testbench

//   Shares one combinational sign-magnitude adder between NREQ requesters.

---
 rtl/sm_add_pkg.sv | 20 ++
 rtl/sm_add.sv | 53 +++++
 rtl/sm_add_arbiter.sv | 119 +++++++++++
 tb/tb_sm_add_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_add_pkg.sv
// Shared widths, types and slot-state encoding for the sm_add arbiter slice.
// Optional feature macro: SM_ADD_SATURATE_EN (see sm_add.sv).
package sm_add_pkg;

  localparam int unsigned SM_W    = 8;
  localparam int unsigned SM_NREQ = 4;

  typedef logic [SM_W-1:0] sm_word_t;

  typedef struct packed {
    sm_word_t sum;
    logic     ovf;
  } sm_res_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/sm_add.sv
// Combinational sign-magnitude adder: bit W-1 is the sign, bits W-2:0 the magnitude.
// SM_ADD_SATURATE_EN defined: same-sign overflow clamps the magnitude to all-ones.
module sm_add
  import sm_add_pkg::*;
#(
  parameter int unsigned W = SM_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam int unsigned M = W - 1;

  logic         sa;
  logic         sb;
  logic [M-1:0] ma;
  logic [M-1:0] mb;
  logic [M:0]   same_sum;
  logic [M-1:0] diff_ab;
  logic [M-1:0] diff_ba;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ma = a[M-1:0];
  assign mb = b[M-1:0];

  // Add magnitudes for like signs, otherwise subtract smaller from larger.
  always_comb begin
    same_sum = {1'b0, ma} + {1'b0, mb};
    diff_ab  = ma - mb;
    diff_ba  = mb - ma;
    sum      = '0;
    ovf      = 1'b0;
    if (sa == sb) begin
      ovf = same_sum[M];
`ifdef SM_ADD_SATURATE_EN
      sum = same_sum[M] ? {sa, {M{1'b1}}} : {sa, same_sum[M-1:0]};
`else
      sum = {sa, same_sum[M-1:0]};
`endif
    end else if (ma > mb) begin
      sum = {sa, diff_ab};
    end else if (mb > ma) begin
      sum = {sb, diff_ba};
    end else begin
      // Equal magnitudes cancel to +0, never -0.
      sum = '0;
    end
  end

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter sharing one sm_add among NREQ requesters, with a single
// registered result slot and a saturating overflow counter.
// Optional feature macro: SM_ADD_SATURATE_EN (passed through to sm_add).
module sm_add_arbiter
  import sm_add_pkg::*;
#(
  parameter  int unsigned NREQ = SM_NREQ,
  parameter  int unsigned W    = SM_W,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_ovf,
  output logic [IDW-1:0]    res_id,
  output logic [15:0]       ovf_cnt
);

  slot_state_t    state;
  logic [IDW-1:0] rr_ptr;
  logic           can_accept;
  logic           accept;
  logic           found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   add_sum;
  logic           add_ovf;

  assign res_valid  = (state == FULL);
  assign can_accept = !res_valid || res_ready;
  assign accept     = can_accept && found;

  // Pick the first valid requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One-hot grant, gated by slot availability; independent of operand data.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant_idx == IDW'(i));
    end
  end

  // Route the granted operand pair to the shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
      end
    end
  end

  sm_add #(
    .W (W)
  ) u_sm_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Result slot: accept overrides pop so a pop+accept stays FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      res_sum <= '0;
      res_ovf <= 1'b0;
      res_id  <= '0;
    end else if (accept) begin
      state   <= FULL;
      res_sum <= add_sum;
      res_ovf <= add_ovf;
      res_id  <= grant_idx;
    end else if (res_valid && res_ready) begin
      state   <= EMPTY;
    end
  end

  // Advance the round-robin pointer past the requester just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Count accepted operations that overflowed, holding at full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (accept && add_ovf && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Self-checking bench for sm_add_arbiter: directed steps then randomized traffic,
// compared against a value-level reference model of arbitration and arithmetic.
module tb_sm_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_sum;
  logic        res_ovf;
  logic [1:0]  res_id;
  logic [15:0] ovf_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] a_arr [4];
  logic [7:0] b_arr [4];

  // Reference model state
  bit         m_valid;
  logic [7:0] m_sum;
  bit         m_ovf;
  int         m_id;
  int         m_cnt;
  int         m_ptr;

  always #5 clk = ~clk;

  sm_add_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .ovf_cnt   (ovf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed-value arithmetic: returns {ovf, sum}.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int ma, mb, va, vb, s, v;
    logic [7:0] mag;
    bit ovf;
    logic [7:0] sum;
    ma = int'(a[6:0]);
    mb = int'(b[6:0]);
    if (a[7] == b[7]) begin
      s   = ma + mb;
      ovf = (s > 127);
`ifdef SM_ADD_SATURATE_EN
      if (ovf) s = 127;
`endif
      mag = 8'(s % 128);
      sum = {a[7], mag[6:0]};
    end else begin
      va  = a[7] ? -ma : ma;
      vb  = b[7] ? -mb : mb;
      v   = va + vb;
      ovf = 1'b0;
      mag = 8'((v < 0) ? -v : v);
      sum = {(v < 0), mag[6:0]};
    end
    return {ovf, sum};
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*8 +: 8] = a_arr[i];
      req_b[i*8 +: 8] = b_arr[i];
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_sum   = 8'h00;
    m_ovf   = 1'b0;
    m_id    = 0;
    m_cnt   = 0;
    m_ptr   = 0;
  endtask

  // One clock: check grant before the edge, advance model, check outputs after.
  task automatic step();
    int         g;
    int         idx;
    bit         can;
    logic [3:0] exp_rdy;
    logic [8:0] r;
    drive_ops();
    #1;
    can = !m_valid || res_ready;
    g   = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_rdy = (can && g >= 0) ? 4'(1 << g) : 4'h0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (can && g >= 0) begin
      r       = ref_add(a_arr[g], b_arr[g]);
      m_valid = 1'b1;
      m_sum   = r[7:0];
      m_ovf   = r[8];
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
      if (r[8] && m_cnt < 65535) m_cnt++;
    end else if (m_valid && res_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
    if (m_valid) begin
      chk("res_sum", 32'(res_sum), 32'(m_sum));
      chk("res_ovf", 32'(res_ovf), 32'(m_ovf));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'h0;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 8'h00;
      b_arr[i] = 8'h00;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_sum", 32'(res_sum), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Simple positive add from requester 0
    a_arr[0] = 8'h05; b_arr[0] = 8'h03; req_valid = 4'b0001;
    step();
    chk("t1_sum_08", 32'(res_sum), 32'h08);

    // Opposite signs: larger-magnitude negative, then exact cancellation
    a_arr[0] = 8'h85; b_arr[0] = 8'h03;
    step();
    chk("t2_sum_82", 32'(res_sum), 32'h82);
    a_arr[0] = 8'h03; b_arr[0] = 8'h83;
    step();
    chk("t2_sum_00", 32'(res_sum), 32'h00);

    // Same-sign overflow
    a_arr[0] = 8'h40; b_arr[0] = 8'h40;
    step();
`ifdef SM_ADD_SATURATE_EN
    chk("t3_sum_sat", 32'(res_sum), 32'h7F);
`else
    chk("t3_sum_wrap", 32'(res_sum), 32'h00);
`endif
    chk("t3_ovf", 32'(res_ovf), 32'd1);
    chk("t3_cnt", 32'(ovf_cnt), 32'd1);
    req_valid = 4'h0;
    step();

    // All four requesting with a free consumer: rotating grants, one per cycle
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 8'(8'h10 + i);
      b_arr[i] = 8'(8'h81 + i);
    end
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) step();

    // Back-pressure: slot held, no grants, outputs stable
    res_ready = 1'b0;
    for (int n = 0; n < 5; n++) step();
    res_ready = 1'b1;
    step();
    step();

    // Steer the pointer away from 0, then reset while a result is held
    req_valid = 4'b0100;
    a_arr[2] = 8'h7F; b_arr[2] = 8'h01;
    step();
    req_valid = 4'h0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(res_valid), 32'd0);
    chk("t6_async_cnt", 32'(ovf_cnt), 32'd0);
    chk("t6_async_sum", 32'(res_sum), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1010;
    step();
    chk("t6_grant_from_0", 32'(res_id), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = 8'($urandom);
        b_arr[i] = 8'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
